// File: rtl/vga_timing_controller_if.sv
// Pixel-side bundle between the VGA timing controller and the graphics generator.
// The controller is the master: it owns the scan counters, strobes and pin drives.
interface vga_timing_controller_if;
  logic [3:0] redIn;
  logic [3:0] greenIn;
  logic [3:0] blueIn;
  logic [9:0] horizCount;
  logic [9:0] vertCount;
  logic       pixelTick;
  logic       frameTick;
  logic [3:0] vgaRed;
  logic [3:0] vgaGreen;
  logic [3:0] vgaBlue;
  logic       hsync;
  logic       vsync;

  modport master (
    input  redIn, greenIn, blueIn,
    output horizCount, vertCount, pixelTick, frameTick,
    output vgaRed, vgaGreen, vgaBlue, hsync, vsync
  );

  modport slave (
    output redIn, greenIn, blueIn,
    input  horizCount, vertCount, pixelTick, frameTick,
    input  vgaRed, vgaGreen, vgaBlue, hsync, vsync
  );
endinterface

// File: rtl/vga_timing_controller.sv
// 640x480@60 VGA timing: pixel-rate divider, scan counters, frame strobe and a
// single registered output stage carrying blanked colour and sync to the pins.
module vga_timing_controller #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        SYNC_POL  = 1'b0
) (
  input logic                      clk,
  input logic                      rst_n,
  vga_timing_controller_if.master  vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;

  logic visible;
  logic in_hsync;
  logic in_vsync;

  assign visible  = (h_q < H_VIS) && (v_q < V_VIS);
  assign in_hsync = (h_q >= H_SYNC_LO) && (h_q < H_SYNC_HI);
  assign in_vsync = (v_q >= V_SYNC_LO) && (v_q < V_SYNC_HI);

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path
    // through the conditionals below can leave one unassigned and infer a latch.
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    // The strobe is registered so it stays low in reset even when CLK_DIV is 1.
    tick_d = (div_d == DIV_LAST);
    h_d    = h_q;
    v_d    = v_q;
    rgb_d  = rgb_q;
    hs_d   = hs_q;
    vs_d   = vs_q;

    if (tick_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      // Colour and sync are captured from the pre-update counts in one stage.
      rgb_d = visible ? {vga.redIn, vga.greenIn, vga.blueIn} : 12'h000;
      hs_d  = in_hsync ? SYNC_POL : ~SYNC_POL;
      vs_d  = in_vsync ? SYNC_POL : ~SYNC_POL;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      rgb_q  <= '0;
      hs_q   <= ~SYNC_POL;
      vs_q   <= ~SYNC_POL;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      h_q    <= h_d;
      v_q    <= v_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign vga.horizCount = h_q;
  assign vga.vertCount  = v_q;
  assign vga.pixelTick  = tick_q;
  assign vga.frameTick  = tick_q && (h_q == H_LAST) && (v_q == V_LAST);
  assign vga.vgaRed     = rgb_q[11:8];
  assign vga.vgaGreen   = rgb_q[7:4];
  assign vga.vgaBlue    = rgb_q[3:0];
  assign vga.hsync      = hs_q;
  assign vga.vsync      = vs_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Scoreboard bench: dut_a uses the 640x480 timing, dut_b a tiny 8x7 raster with
// CLK_DIV=1 and active-high sync so whole frames fit in a short run.
module tb_vga_timing_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a;
  logic rst_n_b;

  vga_timing_controller_if if_a();
  vga_timing_controller_if if_b();

  vga_timing_controller dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .vga   (if_a)
  );

  vga_timing_controller #(
    .CLK_DIV   (1),
    .H_VISIBLE (4),
    .H_FRONT   (1),
    .H_SYNC    (2),
    .H_BACK    (1),
    .V_VISIBLE (3),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (1),
    .SYNC_POL  (1'b1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .vga   (if_b)
  );

  typedef struct {
    int          k;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        ft;
  } item_t;

  item_t q_a[$];
  item_t q_b[$];
  item_t e_a;
  item_t e_b;

  int tests  = 0;
  int failed = 0;
  int tick_a = 0;
  int tick_b = 0;
  int hs_low_a  = 0;
  int vs_act_b  = 0;
  int ft_cnt_b  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic item_t mk(input int k, input int h, input int v, input int rgb,
                               input logic hs, input logic vs, input logic ft);
    item_t it;
    it.k   = k;
    it.h   = 10'(h);
    it.v   = 10'(v);
    it.rgb = 12'(rgb);
    it.hs  = hs;
    it.vs  = vs;
    it.ft  = ft;
    return it;
  endfunction

  task automatic compare(input string tag, input item_t e, input int k,
                         input logic [9:0] h, input logic [9:0] v, input logic [11:0] rgb,
                         input logic hs, input logic vs, input logic ft);
    string p;
    p = $sformatf("%s k=%0d", tag, e.k);
    check({p, " tick"}, 32'(k), 32'(e.k));
    check({p, " h"},    32'(h), 32'(e.h));
    check({p, " v"},    32'(v), 32'(e.v));
    check({p, " rgb"},  32'(rgb), 32'(e.rgb));
    check({p, " hsync"}, 32'(hs), 32'(e.hs));
    check({p, " vsync"}, 32'(vs), 32'(e.vs));
    check({p, " frameTick"}, 32'(ft), 32'(e.ft));
  endtask

  // Monitors: each pixelTick is one presented pixel; pop every expectation due now.
  always @(negedge clk) begin
    if (!rst_n_a) begin
      tick_a   = 0;
      hs_low_a = 0;
    end else if (if_a.pixelTick) begin
      while (q_a.size() > 0 && q_a[0].k <= tick_a) begin
        e_a = q_a.pop_front();
        compare("a", e_a, tick_a, if_a.horizCount, if_a.vertCount,
                {if_a.vgaRed, if_a.vgaGreen, if_a.vgaBlue},
                if_a.hsync, if_a.vsync, if_a.frameTick);
      end
      if (!if_a.hsync) hs_low_a++;
      tick_a++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n_b) begin
      tick_b   = 0;
      vs_act_b = 0;
      ft_cnt_b = 0;
    end else if (if_b.pixelTick) begin
      while (q_b.size() > 0 && q_b[0].k <= tick_b) begin
        e_b = q_b.pop_front();
        compare("b", e_b, tick_b, if_b.horizCount, if_b.vertCount,
                {if_b.vgaRed, if_b.vgaGreen, if_b.vgaBlue},
                if_b.hsync, if_b.vsync, if_b.frameTick);
      end
      if (tick_b >= 1 && tick_b <= 56 && if_b.vsync) vs_act_b++;
      if (if_b.frameTick) ft_cnt_b++;
      tick_b++;
    end
  end

  task automatic wait_tick_a(input int n, input int budget, input string name);
    int c = 0;
    while (tick_a < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(tick_a >= n), 32'd1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, " h"},   32'(if_a.horizCount), 32'd0);
    check({tag, " v"},   32'(if_a.vertCount), 32'd0);
    check({tag, " rgb"}, 32'({if_a.vgaRed, if_a.vgaGreen, if_a.vgaBlue}), 32'd0);
    check({tag, " hsync"}, 32'(if_a.hsync), 32'd1);
    check({tag, " vsync"}, 32'(if_a.vsync), 32'd1);
    check({tag, " pixelTick"}, 32'(if_a.pixelTick), 32'd0);
    check({tag, " frameTick"}, 32'(if_a.frameTick), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad_b;
    int c;
    bit found;

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    if_a.redIn = 4'hF; if_a.greenIn = 4'hA; if_a.blueIn = 4'h5;
    if_b.redIn = 4'h3; if_b.greenIn = 4'hC; if_b.blueIn = 4'h9;
    repeat (3) @(negedge clk);

    check_reset_a("a_reset");
    check("b_reset hsync", 32'(if_b.hsync), 32'd0);
    check("b_reset vsync", 32'(if_b.vsync), 32'd0);
    check("b_reset pixelTick", 32'(if_b.pixelTick), 32'd0);

    // Tick k shows counts of pixel k; outputs were captured from pixel k-1.
    q_a.push_back(mk(0,   0,   0, 12'h000, 1'b1, 1'b1, 1'b0));
    q_a.push_back(mk(1,   1,   0, 12'hFA5, 1'b1, 1'b1, 1'b0));
    q_a.push_back(mk(640, 640, 0, 12'hFA5, 1'b1, 1'b1, 1'b0));
    q_a.push_back(mk(641, 641, 0, 12'h000, 1'b1, 1'b1, 1'b0));
    q_a.push_back(mk(656, 656, 0, 12'h000, 1'b1, 1'b1, 1'b0));
    q_a.push_back(mk(657, 657, 0, 12'h000, 1'b0, 1'b1, 1'b0));
    q_a.push_back(mk(752, 752, 0, 12'h000, 1'b0, 1'b1, 1'b0));
    q_a.push_back(mk(753, 753, 0, 12'h000, 1'b1, 1'b1, 1'b0));
    q_a.push_back(mk(799, 799, 0, 12'h000, 1'b1, 1'b1, 1'b0));
    q_a.push_back(mk(800, 0,   1, 12'h000, 1'b1, 1'b1, 1'b0));
    q_a.push_back(mk(801, 1,   1, 12'hFA5, 1'b1, 1'b1, 1'b0));

    q_b.push_back(mk(0,  0, 0, 12'h000, 1'b0, 1'b0, 1'b0));
    q_b.push_back(mk(1,  1, 0, 12'h3C9, 1'b0, 1'b0, 1'b0));
    q_b.push_back(mk(6,  6, 0, 12'h000, 1'b1, 1'b0, 1'b0));
    q_b.push_back(mk(8,  0, 1, 12'h000, 1'b0, 1'b0, 1'b0));
    q_b.push_back(mk(20, 4, 2, 12'h3C9, 1'b0, 1'b0, 1'b0));
    q_b.push_back(mk(25, 1, 3, 12'h000, 1'b0, 1'b0, 1'b0));
    q_b.push_back(mk(33, 1, 4, 12'h000, 1'b0, 1'b1, 1'b0));
    q_b.push_back(mk(55, 7, 6, 12'h000, 1'b1, 1'b0, 1'b1));
    q_b.push_back(mk(56, 0, 0, 12'h000, 1'b0, 1'b0, 1'b0));
    q_b.push_back(mk(57, 1, 0, 12'h3C9, 1'b0, 1'b0, 1'b0));

    @(negedge clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Divider: tick on every 4th clk, counts frozen between ticks.
    bad_b = 0;
    for (int i = 0; i <= 40; i++) begin
      check($sformatf("a_rate i=%0d pixelTick", i), 32'(if_a.pixelTick), 32'((i % 4) == 3));
      check($sformatf("a_rate i=%0d h", i), 32'(if_a.horizCount), 32'(i / 4));
      if (i == 0) check("b_first pixelTick", 32'(if_b.pixelTick), 32'd0);
      else if (!if_b.pixelTick) bad_b++;
      @(negedge clk);
    end

    c = 0;
    while (tick_b < 170 && c < 500) begin
      if (!if_b.pixelTick) bad_b++;
      @(negedge clk);
      c++;
    end
    check("b_reach 170 ticks", 32'(tick_b >= 170), 32'd1);
    check("b_pixelTick tied high", 32'(bad_b), 32'd0);
    check("b_frameTick count 3 frames", 32'(ft_cnt_b), 32'd3);
    check("b_vsync active pixels per frame", 32'(vs_act_b), 32'd16);
    check("b_scoreboard drained", 32'(q_b.size()), 32'd0);

    wait_tick_a(802, 4000, "a_reach line 1");
    check("a_hsync low pixels in line", 32'(hs_low_a), 32'd96);
    check("a_scoreboard drained", 32'(q_a.size()), 32'd0);

    // Mid-frame reset at h=300, v=1.
    found = 1'b0;
    c = 0;
    while (!found && c < 2000) begin
      @(negedge clk);
      c++;
      if (if_a.pixelTick && if_a.horizCount == 10'd300 && if_a.vertCount == 10'd1) found = 1'b1;
    end
    check("a_reach h=300 v=1", 32'(found), 32'd1);
    #1 rst_n_a = 1'b0;
    #1 check_reset_a("a_midframe_reset");

    q_a.push_back(mk(0, 0, 0, 12'h000, 1'b1, 1'b1, 1'b0));
    q_a.push_back(mk(1, 1, 0, 12'hFA5, 1'b1, 1'b1, 1'b0));
    q_a.push_back(mk(2, 2, 0, 12'hFA5, 1'b1, 1'b1, 1'b0));
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;

    c = 0;
    while (!if_a.pixelTick && c < 10) begin
      @(posedge clk);
      @(negedge clk);
      c++;
    end
    check("a_clks to first tick after reset", 32'(c), 32'd3);
    wait_tick_a(3, 50, "a_reach 3 ticks after reset");
    check("a_restart scoreboard drained", 32'(q_a.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
